// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg
// Shared definitions for the multiplexed seven-segment driver.
// Contents:
//   SEG_0..SEG_9, SEG_DASH, SEG_BLANK : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   bcd_to_seg   : one BCD digit to its glyph (codes 10-15 show blank)
//   idx_width    : width of a digit index for a given digit count
//   max_display  : largest value a given number of decimal digits can show
package sev_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Codes 10-15 never come out of the converter; they fall to blank.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] pattern;
      case (bcd)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

   function automatic logic [63:0] max_display(input int digits);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < digits; i++) begin
         r = r * 64'd10;
      end
      return r - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary to BCD converter, one shift/add-3 step per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load value and begin (ignored while busy)
//   value      : unsigned binary input, VAL_W bits
//   busy       : conversion in progress (high from the load edge until the done edge)
//   done       : high for the final busy cycle; bcd holds the finished result
//   bcd        : DIGITS packed BCD nibbles, digit 0 in the low nibble
module bin2bcd_seq
   import sev_seg_pkg::*;
#(
   parameter int VAL_W  = 8,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [VAL_W-1:0]    value,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);

   localparam int SR_W  = VAL_W + 4*DIGITS;
   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [SR_W-1:0]  shift_reg;
   logic [SR_W-1:0]  shift_step;
   logic [CNT_W-1:0] step_cnt;

   // After VAL_W steps the counter parks for one cycle, announcing done,
   // so the result is taken on the following edge.
   assign done = busy && (step_cnt == CNT_W'(VAL_W));
   assign bcd  = shift_reg[VAL_W +: 4*DIGITS];

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   always_comb begin
      shift_step = shift_reg;
      for (int d = 0; d < DIGITS; d++) begin
         if (shift_step[VAL_W + 4*d +: 4] >= 4'd5) begin
            shift_step[VAL_W + 4*d +: 4] = shift_step[VAL_W + 4*d +: 4] + 4'd3;
         end
      end
      shift_step = shift_step << 1;
   end

   // Load on start, step while busy, drop busy on the edge after the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         step_cnt  <= '0;
         busy      <= 1'b0;
      end else if (start && !busy) begin
         shift_reg <= {{(4*DIGITS){1'b0}}, value};
         step_cnt  <= '0;
         busy      <= 1'b1;
      end else if (busy) begin
         if (done) begin
            busy <= 1'b0;
         end else begin
            shift_reg <= shift_step;
            step_cnt  <= step_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sev_seg_scan.sv
// sev_seg_scan
// N-digit multiplexed seven-segment driver. A binary value accepted over a
// valid/ready handshake is converted to BCD and displayed, digits scanned
// with a programmable refresh divider.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : new value offered
//   in_ready   : converter idle; value taken when in_valid & in_ready
//   in_value   : unsigned binary value, VAL_W bits
//   an         : digit enables, active-low, digit 0 is least significant
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   ovf        : displayed value exceeded 10^DIGITS-1 (digits show dashes)
// Optional feature: define SEV_SEG_LZ_BLANK_EN for leading-zero blanking.
module sev_seg_scan
   import sev_seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int VAL_W       = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [VAL_W-1:0]  in_value,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              ovf
);

   localparam int IDX_W = idx_width(DIGITS);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int CMP_W = (VAL_W > 32) ? VAL_W : 32;
   localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(max_display(DIGITS));

   logic                start;
   logic                busy;
   logic                done;
   logic                too_big;
   logic                ovf_pend;
   logic                ovf_nxt;
   logic [4*DIGITS-1:0] bcd;
   logic [4*DIGITS-1:0] digits;
   logic [4*DIGITS-1:0] digits_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic                wrap;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_nxt;
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   an_nxt;
   logic [3:0]          nibble;
   logic [6:0]          seg_nxt;

   assign in_ready = ~busy;
   assign start    = in_valid & in_ready;
   assign too_big  = CMP_W'(in_value) > MAX_VAL;

   bin2bcd_seq #(
      .VAL_W  (VAL_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .value (in_value),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   // The overflow decision is made on the accepted value and held until the
   // conversion lands, so digits and ovf switch together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_pend <= 1'b0;
      end else if (start) begin
         ovf_pend <= too_big;
      end
   end

   // Next display contents and scan position; outputs are built from these
   // so a digit selected on the same edge as an update shows the new value.
   always_comb begin
      digits_nxt = digits;
      ovf_nxt    = ovf;
      if (done) begin
         digits_nxt = bcd;
         ovf_nxt    = ovf_pend;
      end
      wrap    = (div_cnt == DIV_W'(REFRESH_DIV - 1));
      idx_nxt = idx;
      if (wrap) begin
         idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
   end

`ifdef SEV_SEG_LZ_BLANK_EN
   logic zero_above;

   // Walk down from the top digit; every digit whose own nibble and all
   // higher nibbles are zero is blanked. Digit 0 is never blanked.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int d = DIGITS - 1; d > 0; d--) begin
         zero_above = zero_above & (digits_nxt[4*d +: 4] == 4'd0);
         blank[d]   = zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   // Glyph for the selected digit: dashes on overflow take priority over blanking.
   always_comb begin
      an_nxt = ~(DIGITS'(1) << idx_nxt);
      nibble = digits_nxt[4*idx_nxt +: 4];
      if (ovf_nxt) begin
         seg_nxt = SEG_DASH;
      end else if (blank[idx_nxt]) begin
         seg_nxt = SEG_BLANK;
      end else begin
         seg_nxt = bcd_to_seg(nibble);
      end
   end

   // Display registers, refresh divider, scan index and the registered pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits  <= '0;
         ovf     <= 1'b0;
         div_cnt <= '0;
         idx     <= '0;
         an      <= '1;
         seg     <= SEG_BLANK;
      end else begin
         digits  <= digits_nxt;
         ovf     <= ovf_nxt;
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         idx     <= idx_nxt;
         an      <= an_nxt;
         seg     <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_sev_seg_scan.sv
// tb_sev_seg_scan
// Self-checking bench for sev_seg_scan. Two instances share clock and reset:
// dut8 (VAL_W=8) and dut14 (VAL_W=14, for overflow values), both with
// DIGITS=4 and REFRESH_DIV=4. Honours SEV_SEG_LZ_BLANK_EN in its model.
module tb_sev_seg_scan;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid8, ready8, ovf8;
   logic [7:0] value8;
   logic [3:0] an8;
   logic [6:0] seg8;
   logic        valid14, ready14, ovf14;
   logic [13:0] value14;
   logic [3:0]  an14;
   logic [6:0]  seg14;

   typedef struct packed {
      logic            ovf;
      logic [3:0][6:0] segs;
   } exp_t;

   typedef struct {
      int unsigned value;
      logic [15:0] bcd;
      logic        ovf;
   } vec_t;

   exp_t exp_q[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   mon_bad = 0;
   bit   mon_en = 1'b0;
   logic [6:0] allow_a, allow_b, allow_c;

   // 100 MHz clock
   always #5 clk = ~clk;

   sev_seg_scan #(.DIGITS(4), .VAL_W(8), .REFRESH_DIV(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(valid8), .in_ready(ready8),
      .in_value(value8), .an(an8), .seg(seg8), .ovf(ovf8)
   );

   sev_seg_scan #(.DIGITS(4), .VAL_W(14), .REFRESH_DIV(4)) dut14 (
      .clk(clk), .rst_n(rst_n), .in_valid(valid14), .in_ready(ready14),
      .in_value(value14), .an(an14), .seg(seg14), .ovf(ovf14)
   );

   // Watches digit 0 of dut8 while enabled and counts any glyph outside the allowed set
   always @(negedge clk) begin
      if (mon_en && an8 == 4'b1110 && seg8 !== allow_a && seg8 !== allow_b && seg8 !== allow_c) begin
         mon_bad <= mon_bad + 1;
      end
   end

   // Absolute time limit in case anything stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] bcd, input logic ovf_bit);
      exp_t e;
      bit   zero_above;
      bit   blank;
      zero_above = 1'b1;
      e.ovf = ovf_bit;
      for (int d = 3; d >= 0; d--) begin
         zero_above = zero_above && (bcd[4*d +: 4] == 4'd0);
         blank = 1'b0;
`ifdef SEV_SEG_LZ_BLANK_EN
         blank = zero_above && (d != 0);
`endif
         if (ovf_bit) e.segs[d] = 7'b0111111;
         else if (blank) e.segs[d] = 7'b1111111;
         else e.segs[d] = glyph(bcd[4*d +: 4]);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic ready_of(input bit big);
      return big ? ready14 : ready8;
   endfunction

   function automatic logic ovf_of(input bit big);
      return big ? ovf14 : ovf8;
   endfunction

   function automatic logic [3:0] an_of(input bit big);
      return big ? an14 : an8;
   endfunction

   function automatic logic [6:0] seg_of(input bit big);
      return big ? seg14 : seg8;
   endfunction

   task automatic drive(input bit big, input bit v, input int unsigned val);
      if (big) begin
         valid14 = v;
         value14 = 14'(val);
      end else begin
         valid8 = v;
         value8 = 8'(val);
      end
   endtask

   // Offer a value once ready, push its expected display when it is accepted
   task automatic applyStimulus(input bit big, input int unsigned val, input logic [15:0] bcd, input logic ovf_bit);
      bit got_ready;
      got_ready = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ready_of(big)) begin
            got_ready = 1'b1;
            break;
         end
      end
      check("ready before send", 32'(got_ready), 32'd1);
      drive(big, 1'b1, val);
      @(posedge clk);
      exp_q.push_back(model(bcd, ovf_bit));
      #1 drive(big, 1'b0, 0);
   endtask

   // Count negedges with in_ready low until it rises (bounded)
   task automatic wait_done(input bit big, input int exp_low);
      int n;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ready_of(big)) break;
         n++;
      end
      check("ready low cycles", 32'(n), 32'(exp_low));
   endtask

   // Pop the expected display; full=1 scans all digits, full=0 checks the lit digit now
   task automatic checkOutput(input bit big, input bit full);
      exp_t       e;
      logic [3:0] a;
      logic [3:0] sel;
      logic [6:0] seen [4];
      bit         got [4];
      int         bad;
      bit         found;
      if (exp_q.size() == 0) begin
         check("scoreboard not empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("ovf", 32'(ovf_of(big)), 32'(e.ovf));
      if (!full) begin
         a = an_of(big);
         found = 1'b0;
         for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            if (a == sel) begin
               found = 1'b1;
               check("lit digit seg", 32'(seg_of(big)), 32'(e.segs[d]));
            end
         end
         check("lit an one-hot-zero", 32'(found), 32'd1);
         return;
      end
      bad = 0;
      for (int d = 0; d < 4; d++) begin
         got[d] = 1'b0;
         seen[d] = 7'h00;
      end
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         a = an_of(big);
         found = 1'b0;
         for (int d = 0; d < 4; d++) begin
            sel = ~(4'b0001 << d);
            if (a == sel) begin
               found = 1'b1;
               got[d] = 1'b1;
               seen[d] = seg_of(big);
            end
         end
         if (!found) bad++;
      end
      check("an one-hot-zero", 32'(bad), 32'd0);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("digit%0d seen", d), 32'(got[d]), 32'd1);
         check($sformatf("digit%0d seg", d), 32'(seen[d]), 32'(e.segs[d]));
      end
   endtask

   initial begin
      vec_t       t8 [6];
      vec_t       t14 [5];
      exp_t       e;
      logic [3:0] prev;
      logic [3:0] exp_an;
      int         n;
      int         mon_base;
      bit         aligned;

      t8[0] = '{123,   16'h0123, 1'b0};
      t8[1] = '{0,     16'h0000, 1'b0};
      t8[2] = '{255,   16'h0255, 1'b0};
      t8[3] = '{9,     16'h0009, 1'b0};
      t8[4] = '{100,   16'h0100, 1'b0};
      t8[5] = '{7,     16'h0007, 1'b0};
      t14[0] = '{10000, 16'h0000, 1'b1};
      t14[1] = '{42,    16'h0042, 1'b0};
      t14[2] = '{16383, 16'h0000, 1'b1};
      t14[3] = '{9999,  16'h9999, 1'b0};
      t14[4] = '{0,     16'h0000, 1'b0};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 0);
      drive(1'b1, 1'b0, 0);

      // Reset state
      #23;
      check("reset an8", 32'(an8), 32'hF);
      check("reset seg8", 32'(seg8), 32'h7F);
      check("reset ready8", 32'(ready8), 32'd1);
      check("reset ovf8", 32'(ovf8), 32'd0);
      check("reset an14", 32'(an14), 32'hF);
      check("reset seg14", 32'(seg14), 32'h7F);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(16'h0000, 1'b0));
      checkOutput(1'b0, 1'b1);

      // Table: 8-bit instance
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, t8[i].value, t8[i].bcd, t8[i].ovf);
         wait_done(1'b0, 9);
         checkOutput(1'b0, 1'b1);
      end

      // Table: 14-bit instance with overflow and recovery
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, t14[i].value, t14[i].bcd, t14[i].ovf);
         wait_done(1'b1, 15);
         checkOutput(1'b1, 1'b1);
      end

      // Scan order and dwell for 123
      applyStimulus(1'b0, 123, 16'h0123, 1'b0);
      wait_done(1'b0, 9);
      e = exp_q[0];
      prev = an8;
      aligned = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (an8 == 4'b1110 && prev != 4'b1110) begin
            aligned = 1'b1;
            break;
         end
         prev = an8;
      end
      check("scan align", 32'(aligned), 32'd1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         exp_an = ~(4'b0001 << (i / 4));
         check($sformatf("scan an %0d", i), 32'(an8), 32'(exp_an));
         check($sformatf("scan seg %0d", i), 32'(seg8), 32'(e.segs[i / 4]));
      end
      checkOutput(1'b0, 1'b1);

      // Back-to-back: 8 shown, then 5 and 9 with in_valid held
      applyStimulus(1'b0, 8, 16'h0008, 1'b0);
      wait_done(1'b0, 9);
      checkOutput(1'b0, 1'b1);
      allow_a = glyph(4'd8);
      allow_b = glyph(4'd5);
      allow_c = glyph(4'd9);
      mon_base = mon_bad;
      mon_en = 1'b1;
      @(negedge clk);
      drive(1'b0, 1'b1, 5);
      @(posedge clk);
      exp_q.push_back(model(16'h0005, 1'b0));
      #1 value8 = 8'd9;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ready8) break;
         n++;
      end
      check("b2b first busy", 32'(n), 32'd9);
      checkOutput(1'b0, 1'b0);
      @(posedge clk);
      exp_q.push_back(model(16'h0009, 1'b0));
      #1 drive(1'b0, 1'b0, 0);
      @(negedge clk);
      check("b2b second accepted", 32'(ready8), 32'd0);
      wait_done(1'b0, 8);
      checkOutput(1'b0, 1'b1);
      mon_en = 1'b0;
      check("b2b no intermediate", 32'(mon_bad - mon_base), 32'd0);

      // Reset in the middle of a conversion
      applyStimulus(1'b0, 77, 16'h0077, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst an8", 32'(an8), 32'hF);
      check("midrst seg8", 32'(seg8), 32'h7F);
      check("midrst ready8", 32'(ready8), 32'd1);
      check("midrst ovf8", 32'(ovf8), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(16'h0000, 1'b0));
      checkOutput(1'b0, 1'b1);
      applyStimulus(1'b0, 88, 16'h0088, 1'b0);
      wait_done(1'b0, 9);
      checkOutput(1'b0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
